// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and select encodings for the M-extension EX-stage sequencer.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'd0,
        MD_MUL_WAIT = 2'd1,
        MD_DIV_WAIT = 2'd2,
        MD_DONE     = 2'd3
    } md_state_e;

    localparam logic LOW       = 1'b0;
    localparam logic HIGH      = 1'b1;
    localparam logic QUOTIENT  = 1'b0;
    localparam logic REMAINDER = 1'b1;

endpackage

// File: rtl/muldiv_ctrl_special.sv
// RISC-V divide special cases (divide by zero, signed overflow), resolved without the divider.
module md_special_case
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            div_sign,
    input  logic            res_sel,
    output logic            is_special,
    output logic [XLEN-1:0] special_res
);

    logic [XLEN-1:0] int_min;
    logic            div_zero;
    logic            div_ovf;

    always_comb begin
        int_min          = '0;
        int_min[XLEN-1]  = 1'b1;
        div_zero         = (rs2 == '0);
        div_ovf          = div_sign && (rs1 == int_min) && (rs2 == '1);
        is_special       = div_zero || div_ovf;
        special_res      = '0;
        if (div_zero) begin
            special_res = (res_sel == REMAINDER) ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = (res_sel == REMAINDER) ? '0 : rs1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage mul/div sequencer: launches the external multiplier/divider, stalls EX
// until the result is ready, holds it under MEM backpressure and aborts on flush.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_flush,
    input  logic              ex_valid,
    input  logic              ex_is_mul_inst,
    input  logic              ex_is_div_inst,
    input  logic [1:0]        ex_sign_extend,
    input  logic              ex_word_sel,
    input  logic              ex_div_sign,
    input  logic              ex_div_res_sel,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic              mem_allowin,
    output logic              mul_start,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    output logic [1:0]        mul_sign,
    input  logic [2*XLEN-1:0] mul_prod,
    output logic              div_start,
    output logic              div_kill,
    output logic [XLEN-1:0]   div_dividend,
    output logic [XLEN-1:0]   div_divisor,
    output logic              div_signed,
    input  logic              div_done,
    input  logic [XLEN-1:0]   div_quot,
    input  logic [XLEN-1:0]   div_rem,
    output logic              md_ready_go,
    output logic              md_busy,
    output logic [XLEN-1:0]   md_result
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            word_sel_q, word_sel_d;
    logic            res_sel_q, res_sel_d;

    logic            md_op;
    logic            launch_mul, launch_div, kill_div;
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;

    assign md_op = ex_valid && (ex_is_mul_inst || ex_is_div_inst);

    md_special_case #(.XLEN(XLEN)) u_special (
        .rs1         (ex_rs1),
        .rs2         (ex_rs2),
        .div_sign    (ex_div_sign),
        .res_sel     (ex_div_res_sel),
        .is_special  (spec_hit),
        .special_res (spec_res)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        word_sel_d  = word_sel_q;
        res_sel_d   = res_sel_q;
        launch_mul  = 1'b0;
        launch_div  = 1'b0;
        kill_div    = 1'b0;
        md_ready_go = 1'b1;

        unique case (state_q)
            MD_IDLE: begin
                md_ready_go = !md_op;
                if (md_op && !pipe_flush) begin
                    word_sel_d = ex_word_sel;
                    res_sel_d  = ex_div_res_sel;
                    if (ex_is_mul_inst) begin
                        launch_mul = 1'b1;
                        cnt_d      = CNT_W'(MUL_LAT - 1);
                        state_d    = MD_MUL_WAIT;
                    end else if (spec_hit) begin
                        result_d = spec_res;
                        state_d  = MD_DONE;
                    end else begin
                        launch_div = 1'b1;
                        state_d    = MD_DIV_WAIT;
                    end
                end
            end
            MD_MUL_WAIT: begin
                md_ready_go = 1'b0;
                if (pipe_flush) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == '0) begin
                    result_d = (word_sel_q == HIGH) ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
                    state_d  = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MD_DIV_WAIT: begin
                md_ready_go = 1'b0;
                if (pipe_flush) begin
                    kill_div = 1'b1;
                    state_d  = MD_IDLE;
                end else if (div_done) begin
                    result_d = (res_sel_q == REMAINDER) ? div_rem : div_quot;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (pipe_flush || mem_allowin) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            word_sel_q <= 1'b0;
            res_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            word_sel_q <= word_sel_d;
            res_sel_q  <= res_sel_d;
        end
    end

    // Strobes are masked during reset: the divider shares rst_n and needs no kill.
    assign mul_start    = rst_n && launch_mul;
    assign div_start    = rst_n && launch_div;
    assign div_kill     = rst_n && kill_div;

    assign mul_a        = ex_rs1;
    assign mul_b        = ex_rs2;
    assign mul_sign     = ex_sign_extend;
    assign div_dividend = ex_rs1;
    assign div_divisor  = ex_rs2;
    assign div_signed   = ex_div_sign;

    assign md_busy      = (state_q != MD_IDLE);
    assign md_result    = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a fixed-latency multiplier stub and a hand-driven divider.
module tb_muldiv_ctrl;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MUL_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_flush;
    logic              ex_valid;
    logic              ex_is_mul_inst;
    logic              ex_is_div_inst;
    logic [1:0]        ex_sign_extend;
    logic              ex_word_sel;
    logic              ex_div_sign;
    logic              ex_div_res_sel;
    logic [XLEN-1:0]   ex_rs1;
    logic [XLEN-1:0]   ex_rs2;
    logic              mem_allowin;
    logic              mul_start;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic [1:0]        mul_sign;
    logic [2*XLEN-1:0] mul_prod;
    logic              div_start;
    logic              div_kill;
    logic [XLEN-1:0]   div_dividend;
    logic [XLEN-1:0]   div_divisor;
    logic              div_signed;
    logic              div_done;
    logic [XLEN-1:0]   div_quot;
    logic [XLEN-1:0]   div_rem;
    logic              md_ready_go;
    logic              md_busy;
    logic [XLEN-1:0]   md_result;

    int n_checks = 0;
    int n_fails  = 0;
    int low_cnt;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_flush     (pipe_flush),
        .ex_valid       (ex_valid),
        .ex_is_mul_inst (ex_is_mul_inst),
        .ex_is_div_inst (ex_is_div_inst),
        .ex_sign_extend (ex_sign_extend),
        .ex_word_sel    (ex_word_sel),
        .ex_div_sign    (ex_div_sign),
        .ex_div_res_sel (ex_div_res_sel),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .mem_allowin    (mem_allowin),
        .mul_start      (mul_start),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_sign       (mul_sign),
        .mul_prod       (mul_prod),
        .div_start      (div_start),
        .div_kill       (div_kill),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_signed     (div_signed),
        .div_done       (div_done),
        .div_quot       (div_quot),
        .div_rem        (div_rem),
        .md_ready_go    (md_ready_go),
        .md_busy        (md_busy),
        .md_result      (md_result)
    );

    // Multiplier stub: product appears MUL_LAT cycles after mul_start, junk otherwise.
    logic [63:0] ext_a, ext_b, prod_full, stage0, stage1;
    always_comb begin
        ext_a     = mul_sign[1] ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
        ext_b     = mul_sign[0] ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
        prod_full = ext_a * ext_b;
    end
    always @(posedge clk) begin
        stage0 <= mul_start ? prod_full : 64'hA5A5_5A5A_DEAD_BEEF;
        stage1 <= stage0;
    end
    assign mul_prod = stage1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic is_mul, input logic is_div, input logic [1:0] sgn,
                          input logic ws, input logic dsg, input logic rsel,
                          input logic [31:0] a, input logic [31:0] b);
        ex_valid       = 1'b1;
        ex_is_mul_inst = is_mul;
        ex_is_div_inst = is_div;
        ex_sign_extend = sgn;
        ex_word_sel    = ws;
        ex_div_sign    = dsg;
        ex_div_res_sel = rsel;
        ex_rs1         = a;
        ex_rs2         = b;
    endtask

    task automatic idle_ex();
        ex_valid       = 1'b0;
        ex_is_mul_inst = 1'b0;
        ex_is_div_inst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pipe_flush = 1'b0; mem_allowin = 1'b1;
        div_done = 1'b0; div_quot = '0; div_rem = '0;
        ex_sign_extend = '0; ex_word_sel = 1'b0; ex_div_sign = 1'b0; ex_div_res_sel = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0;
        idle_ex();

        @(negedge clk); @(negedge clk); #1;
        check_eq("rst_busy", md_busy, 0);
        check_eq("rst_ready_go", md_ready_go, 1);
        check_eq("rst_result", md_result, 0);
        check_eq("rst_mul_start", mul_start, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_div_kill", div_kill, 0);
        rst_n = 1'b1;

        // MULHU 0xFFFFFFFF * 0xFFFFFFFF, high half
        @(negedge clk); set_op(1, 0, 2'b00, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        check_eq("mulhu_start", mul_start, 1);
        check_eq("mulhu_rg_c0", md_ready_go, 0);
        check_eq("mulhu_a", mul_a, 32'hFFFF_FFFF);
        check_eq("mulhu_sign", mul_sign, 2'b00);
        @(negedge clk); #1;
        check_eq("mulhu_start_c1", mul_start, 0);
        check_eq("mulhu_rg_c1", md_ready_go, 0);
        check_eq("mulhu_busy_c1", md_busy, 1);
        @(negedge clk); #1;
        check_eq("mulhu_rg_c2", md_ready_go, 0);
        @(negedge clk); #1;
        check_eq("mulhu_rg_c3", md_ready_go, 1);
        check_eq("mulhu_result", md_result, 32'hFFFF_FFFE);

        // DIVU / REMU by zero
        @(negedge clk); set_op(0, 1, 2'b00, 0, 0, 0, 32'h7, 32'h0); #1;
        check_eq("divu0_start", div_start, 0);
        check_eq("divu0_rg_c0", md_ready_go, 0);
        @(negedge clk); #1;
        check_eq("divu0_rg_c1", md_ready_go, 1);
        check_eq("divu0_result", md_result, 32'hFFFF_FFFF);
        @(negedge clk); set_op(0, 1, 2'b00, 0, 0, 1, 32'h7, 32'h0); #1;
        check_eq("remu0_start", div_start, 0);
        @(negedge clk); #1;
        check_eq("remu0_rg", md_ready_go, 1);
        check_eq("remu0_result", md_result, 32'h7);

        // Signed overflow INT_MIN / -1
        @(negedge clk); set_op(0, 1, 2'b00, 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF); #1;
        check_eq("divovf_start", div_start, 0);
        @(negedge clk); #1;
        check_eq("divovf_rg", md_ready_go, 1);
        check_eq("divovf_result", md_result, 32'h8000_0000);
        @(negedge clk); set_op(0, 1, 2'b00, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF); #1;
        check_eq("removf_start", div_start, 0);
        @(negedge clk); #1;
        check_eq("removf_result", md_result, 32'h0);

        // Signed DIV -7/2, div_done 33 cycles after div_start
        @(negedge clk); set_op(0, 1, 2'b00, 0, 1, 0, 32'hFFFF_FFF9, 32'h2); #1;
        check_eq("div_start", div_start, 1);
        check_eq("div_signed", div_signed, 1);
        check_eq("div_dividend", div_dividend, 32'hFFFF_FFF9);
        check_eq("div_divisor", div_divisor, 32'h2);
        low_cnt = md_ready_go ? 0 : 1;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 33) begin
                div_done = 1'b1; div_quot = 32'hFFFF_FFFD; div_rem = 32'hFFFF_FFFF;
            end
            #1;
            if (!md_ready_go) low_cnt++;
            if (c == 1) check_eq("div_start_c1", div_start, 0);
        end
        @(negedge clk); div_done = 1'b0; div_quot = 32'h1234_5678; #1;
        if (!md_ready_go) low_cnt++;
        check_eq("div_low_cycles", low_cnt, 34);
        check_eq("div_result", md_result, 32'hFFFF_FFFD);

        // Flush at cycle 10 of DIV_WAIT, late div_done ignored
        @(negedge clk); set_op(0, 1, 2'b00, 0, 0, 0, 32'd100, 32'd7); #1;
        check_eq("flush_div_start", div_start, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) pipe_flush = 1'b1;
            #1;
            if (c == 9) check_eq("flush_kill_c9", div_kill, 0);
        end
        check_eq("flush_kill_c10", div_kill, 1);
        @(negedge clk); pipe_flush = 1'b0; idle_ex(); #1;
        check_eq("flush_busy", md_busy, 0);
        check_eq("flush_kill_c11", div_kill, 0);
        check_eq("flush_result_kept", md_result, 32'hFFFF_FFFD);
        for (int c = 12; c <= 33; c++) begin
            @(negedge clk);
            if (c == 33) begin
                div_done = 1'b1; div_quot = 32'd14; div_rem = 32'd2;
            end
        end
        @(negedge clk); div_done = 1'b0; #1;
        check_eq("late_done_busy", md_busy, 0);
        check_eq("late_done_result", md_result, 32'hFFFF_FFFD);

        // Signed MUL -3*5 after the flush, low half
        set_op(1, 0, 2'b11, 0, 0, 0, 32'hFFFF_FFFD, 32'h5); #1;
        check_eq("mul_post_flush_start", mul_start, 1);
        check_eq("mul_post_flush_sign", mul_sign, 2'b11);
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        check_eq("mul_post_flush_rg", md_ready_go, 1);
        check_eq("mul_post_flush_result", md_result, 32'hFFFF_FFF1);

        // Flush in IDLE blocks launch
        @(negedge clk); pipe_flush = 1'b1; set_op(1, 0, 2'b00, 0, 0, 0, 32'h3, 32'h3); #1;
        check_eq("idle_flush_no_start", mul_start, 0);
        @(negedge clk); pipe_flush = 1'b0; idle_ex(); #1;
        check_eq("idle_flush_busy", md_busy, 0);

        // MEM backpressure in DONE, then back-to-back MUL
        @(negedge clk); mem_allowin = 1'b0; set_op(1, 0, 2'b00, 0, 0, 0, 32'h1234_5678, 32'h10); #1;
        check_eq("bp_mul_start", mul_start, 1);
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            div_done = (k == 2);
            div_quot = 32'hCAFE_F00D;
            #1;
            check_eq("bp_hold_rg", md_ready_go, 1);
            check_eq("bp_hold_result", md_result, 32'h2345_6780);
        end
        @(negedge clk); mem_allowin = 1'b1; div_done = 1'b0; #1;
        check_eq("bp_release_busy", md_busy, 1);
        check_eq("bp_release_result", md_result, 32'h2345_6780);
        @(negedge clk); set_op(1, 0, 2'b11, 1, 0, 0, 32'h8000_0000, 32'h8000_0000); #1;
        check_eq("b2b_idle", md_busy, 0);
        check_eq("b2b_mul_start", mul_start, 1);
        @(negedge clk); #1;
        check_eq("b2b_busy", md_busy, 1);

        // Reset mid MUL_WAIT
        @(negedge clk); rst_n = 1'b0; idle_ex(); #1;
        @(negedge clk); #1;
        check_eq("midrst_busy", md_busy, 0);
        check_eq("midrst_result", md_result, 0);
        check_eq("midrst_rg", md_ready_go, 1);
        check_eq("midrst_mul_start", mul_start, 0);
        rst_n = 1'b1;

        // MULH INT_MIN * INT_MIN after reset
        @(negedge clk); set_op(1, 0, 2'b11, 1, 0, 0, 32'h8000_0000, 32'h8000_0000); #1;
        check_eq("mulh_start", mul_start, 1);
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        check_eq("mulh_rg", md_ready_go, 1);
        check_eq("mulh_result", md_result, 32'h4000_0000);
        @(negedge clk); idle_ex();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
